// File: rtl/aclk_multi_controller.sv
// rtl/aclk_multi_controller.sv - keypad entry, commit and display-mux sequencer for the alarm clock
module aclk_multi_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_ALARMS  = 2,
  parameter int ALARM_SEL_W = 1,
  parameter int KEY_TIMEOUT = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   one_second,
  input  logic                   alarm_button,
  input  logic                   time_button,
  input  logic [3:0]             key,
  input  logic [ALARM_SEL_W-1:0] alarm_sel,
  output logic                   reset_count,
  output logic                   load_new_c,
  output logic                   show_new_time,
  output logic                   show_a,
  output logic                   load_new_a,
  output logic                   shift,
  output logic [ALARM_SEL_W-1:0] alarm_idx,
  output logic [3:0]             digit_count,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_e;

  localparam logic [3:0]             FULL_COUNT = 4'(NUM_DIGITS);
  localparam logic [7:0]             TMO_LAST   = 8'(KEY_TIMEOUT - 1);
  localparam logic [ALARM_SEL_W-1:0] MAX_IDX    = ALARM_SEL_W'(NUM_ALARMS - 1);

  state_e                 state_q, state_d;
  logic [3:0]             digit_count_q, digit_count_d;
  logic [ALARM_SEL_W-1:0] alarm_idx_q, alarm_idx_d;
  logic [7:0]             inact_q, inact_d;
  logic                   timeout_q, timeout_d;
  logic                   one_sec_q;

  logic                   sec_tick;
  logic                   key_digit;
  logic                   entry_full;
  logic                   expire;
  logic [ALARM_SEL_W-1:0] sel_clamped;

  assign sec_tick    = one_second & ~one_sec_q;
  assign key_digit   = (key <= 4'd9);
  assign entry_full  = (digit_count_q == FULL_COUNT);
  // The tick that would bring the idle count up to KEY_TIMEOUT abandons the entry.
  assign expire      = sec_tick && (inact_q >= TMO_LAST);
  // Out-of-range channel selects fold onto the last existing alarm.
  assign sel_clamped = (alarm_sel >= MAX_IDX) ? MAX_IDX : alarm_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SHOW_TIME;
      digit_count_q <= 4'd0;
      alarm_idx_q   <= '0;
      inact_q       <= 8'd0;
      timeout_q     <= 1'b0;
      one_sec_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      alarm_idx_q   <= alarm_idx_d;
      inact_q       <= inact_d;
      timeout_q     <= timeout_d;
      one_sec_q     <= one_second;
    end
  end

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    alarm_idx_d   = alarm_idx_q;
    inact_d       = inact_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      SHOW_TIME: begin
        if (key_digit) begin
          state_d       = KEY_STORED;
          digit_count_d = 4'd0;
        end else if (alarm_button) begin
          state_d     = SHOW_ALARM;
          alarm_idx_d = sel_clamped;
        end
      end

      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end

      KEY_STORED: begin
        state_d = KEY_WAITED;
        inact_d = 8'd0;
        if (!entry_full) digit_count_d = digit_count_q + 4'd1;
      end

      // Wait for key release so a held digit shifts only once.
      KEY_WAITED: begin
        if (expire) begin
          state_d       = SHOW_TIME;
          timeout_d     = 1'b1;
          digit_count_d = 4'd0;
          inact_d       = 8'd0;
        end else begin
          if (sec_tick) inact_d = inact_q + 8'd1;
          if (!key_digit) state_d = KEY_ENTRY;
        end
      end

      // A fresh digit beats everything; a complete commit beats an expiring entry.
      KEY_ENTRY: begin
        if (key_digit) begin
          state_d = KEY_STORED;
        end else if (alarm_button && entry_full) begin
          state_d     = SET_ALARM_TIME;
          alarm_idx_d = sel_clamped;
        end else if (time_button && entry_full) begin
          state_d = SET_CURRENT_TIME;
        end else if (expire) begin
          state_d       = SHOW_TIME;
          timeout_d     = 1'b1;
          digit_count_d = 4'd0;
          inact_d       = 8'd0;
        end else if (sec_tick) begin
          inact_d = inact_q + 8'd1;
        end
      end

      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;

      default: state_d = SHOW_TIME;
    endcase
  end

  assign shift         = (state_q == KEY_STORED);
  assign show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                         (state_q == KEY_ENTRY);
  assign show_a        = (state_q == SHOW_ALARM);
  assign load_new_a    = (state_q == SET_ALARM_TIME);
  assign load_new_c    = (state_q == SET_CURRENT_TIME);
  assign reset_count   = (state_q == SET_CURRENT_TIME);
  assign alarm_idx     = alarm_idx_q;
  assign digit_count   = digit_count_q;
  assign timeout       = timeout_q;

endmodule
